ospfb_adc_subsys: RTL and testbench

OSPFB_ADC_SUBSYS -- requirements
Module: ospfb_adc_subsys

---
 rtl/ospfb_adc_subsys.sv | 228 ++++++++++++++++++++++
 tb/tb_ospfb_adc_subsys.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ospfb_adc_subsys.sv
// Oversampled PFB ADC front end: decimating ramp ADC model, sample FIFO,
// framing engine with status/event pulses, and a one-shot capture memory.
module ospfb_adc_subsys #(
  parameter int unsigned ADC_BITS          = 8,
  parameter int unsigned WIDTH             = 16,
  parameter int unsigned FFT_LEN           = 64,
  parameter int unsigned DEC_FAC           = 48,
  parameter int unsigned FRAMES            = 32,
  parameter int unsigned SAMP              = FRAMES * FFT_LEN,
  parameter int unsigned FIFO_DEPTH        = 32,
  parameter int unsigned PROG_EMPTY_THRESH = 16,
  parameter int unsigned PROG_FULL_THRESH  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  output logic [2*WIDTH-1:0]                m_axis_fir_tdata,
  output logic                              m_axis_fir_tvalid,
  output logic                              m_axis_fir_tlast,
  output logic [7:0]                        m_axis_fft_status_tdata,
  output logic                              m_axis_fft_status_tvalid,
  output logic                              event_frame_started,
  output logic                              event_tlast_unexpected,
  output logic                              event_tlast_missing,
  output logic                              event_fft_overflow,
  output logic                              event_data_in_channel_halt,
  output logic                              almost_empty,
  output logic                              almost_full,
  output logic                              prog_empty,
  output logic                              prog_full,
  output logic [$clog2(FIFO_DEPTH):0]       rd_count,
  output logic [$clog2(FIFO_DEPTH):0]       wr_count,
  output logic                              vip_full
);

  localparam int unsigned ACC_W  = $clog2(FFT_LEN + DEC_FAC) + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned BEAT_W = $clog2(FFT_LEN);
  localparam int unsigned ADDR_W = $clog2(SAMP);
  localparam int unsigned DATA_W = 2 * WIDTH;
  localparam int unsigned EXT_W  = WIDTH - ADC_BITS;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] ram      [SAMP];

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [ADC_BITS-1:0] ramp_q, ramp_d, ramp_inv;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [7:0]          frame_q, frame_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                vip_full_q, vip_full_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d, samp_word;
  logic                tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [7:0]          status_tdata_q, status_tdata_d;
  logic                status_tvalid_q, status_tvalid_d;
  logic                frame_started_q, frame_started_d;
  logic                overflow_q, overflow_d, halt_q, halt_d;
  logic                almost_empty_q, almost_empty_d, almost_full_q, almost_full_d;
  logic                prog_empty_q, prog_empty_d, prog_full_q, prog_full_d;
  logic                samp_vld, wr_en, rd_en, capture_en, fifo_full, fifo_empty;

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    ramp_d          = ramp_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    beat_d          = beat_q;
    frame_d         = frame_q;
    addr_d          = addr_q;
    vip_full_d      = vip_full_q;
    tdata_d         = tdata_q;
    tvalid_d        = 1'b0;
    tlast_d         = 1'b0;
    status_tdata_d  = status_tdata_q;
    status_tvalid_d = 1'b0;
    frame_started_d = 1'b0;
    overflow_d      = 1'b0;
    halt_d          = 1'b0;
    samp_vld        = 1'b0;
    rd_en           = 1'b0;

    // ADC phase accumulator: one sample per FFT_LEN/DEC_FAC clocks on average
    acc_sum = acc_q + ACC_W'(DEC_FAC);
    if (en) begin
      if (acc_sum >= ACC_W'(FFT_LEN)) begin
        acc_d    = acc_sum - ACC_W'(FFT_LEN);
        samp_vld = 1'b1;
        ramp_d   = ramp_q + ADC_BITS'(1);
      end else begin
        acc_d = acc_sum;
      end
    end
    ramp_inv  = ~ramp_q;
    samp_word = {{EXT_W{ramp_inv[ADC_BITS-1]}}, ramp_inv,
                 {EXT_W{ramp_q[ADC_BITS-1]}}, ramp_q};

    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    wr_en      = samp_vld && !fifo_full;
    overflow_d = samp_vld && fifo_full;

    case (state_q)
      ST_INIT: if (count_q >= CNT_W'(PROG_FULL_THRESH)) state_d = ST_RUN;
      ST_RUN: begin
        if (fifo_empty) halt_d = 1'b1;
        else            rd_en  = 1'b1;
      end
      default: state_d = ST_INIT;
    endcase

    // Framing: beat counter drives tlast, frame_started and frame status
    if (rd_en) begin
      tdata_d         = fifo_mem[rd_ptr_q];
      tvalid_d        = 1'b1;
      frame_started_d = (beat_q == '0);
      if (beat_q == BEAT_W'(FFT_LEN - 1)) begin
        tlast_d         = 1'b1;
        beat_d          = '0;
        frame_d         = frame_q + 8'd1;
        status_tdata_d  = frame_q + 8'd1;
        status_tvalid_d = 1'b1;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    almost_empty_d = (count_d <= CNT_W'(1));
    almost_full_d  = (count_d >= CNT_W'(FIFO_DEPTH - 1));
    prog_empty_d   = (count_d <= CNT_W'(PROG_EMPTY_THRESH));
    prog_full_d    = (count_d >= CNT_W'(PROG_FULL_THRESH));

    capture_en = tvalid_q && !vip_full_q;
    if (capture_en) begin
      addr_d = addr_q + ADDR_W'(1);
      if (addr_q == ADDR_W'(SAMP - 1)) vip_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_INIT;
      acc_q           <= '0;
      ramp_q          <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      beat_q          <= '0;
      frame_q         <= '0;
      addr_q          <= '0;
      vip_full_q      <= 1'b0;
      tdata_q         <= '0;
      tvalid_q        <= 1'b0;
      tlast_q         <= 1'b0;
      status_tdata_q  <= '0;
      status_tvalid_q <= 1'b0;
      frame_started_q <= 1'b0;
      overflow_q      <= 1'b0;
      halt_q          <= 1'b0;
      almost_empty_q  <= 1'b1;
      almost_full_q   <= 1'b0;
      prog_empty_q    <= 1'b1;
      prog_full_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      ramp_q          <= ramp_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      beat_q          <= beat_d;
      frame_q         <= frame_d;
      addr_q          <= addr_d;
      vip_full_q      <= vip_full_d;
      tdata_q         <= tdata_d;
      tvalid_q        <= tvalid_d;
      tlast_q         <= tlast_d;
      status_tdata_q  <= status_tdata_d;
      status_tvalid_q <= status_tvalid_d;
      frame_started_q <= frame_started_d;
      overflow_q      <= overflow_d;
      halt_q          <= halt_d;
      almost_empty_q  <= almost_empty_d;
      almost_full_q   <= almost_full_d;
      prog_empty_q    <= prog_empty_d;
      prog_full_q     <= prog_full_d;
    end
  end

  // Storage arrays carry no reset; their contents are qualified by pointers/flags
  always_ff @(posedge clk) begin
    if (wr_en)      fifo_mem[wr_ptr_q] <= samp_word;
    if (capture_en) ram[addr_q]        <= tdata_q;
  end

  assign m_axis_fir_tdata           = tdata_q;
  assign m_axis_fir_tvalid          = tvalid_q;
  assign m_axis_fir_tlast           = tlast_q;
  assign m_axis_fft_status_tdata    = status_tdata_q;
  assign m_axis_fft_status_tvalid   = status_tvalid_q;
  assign event_frame_started        = frame_started_q;
  assign event_tlast_unexpected     = 1'b0;
  assign event_tlast_missing        = 1'b0;
  assign event_fft_overflow         = overflow_q;
  assign event_data_in_channel_halt = halt_q;
  assign almost_empty               = almost_empty_q;
  assign almost_full                = almost_full_q;
  assign prog_empty                 = prog_empty_q;
  assign prog_full                  = prog_full_q;
  assign rd_count                   = count_q;
  assign wr_count                   = count_q;
  assign vip_full                   = vip_full_q;

endmodule

// File: tb/tb_ospfb_adc_subsys.sv
// Bench for ospfb_adc_subsys: random enable patterns against a stream-level model
// (sample conservation, ramp value per beat index, framing, capture contents).
module tb_ospfb_adc_subsys;

  localparam int FFT_LEN = 64;
  localparam int DEC_FAC = 48;
  localparam int SAMP    = 32 * 64;
  localparam int DEPTH   = 32;
  localparam int THRESH  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [31:0] fir_tdata;
  logic        fir_tvalid, fir_tlast;
  logic [7:0]  st_tdata;
  logic        st_tvalid;
  logic        ev_fs, ev_tu, ev_tm, ev_ovf, ev_halt;
  logic        a_empty, a_full, p_empty, p_full;
  logic [5:0]  rd_count, wr_count;
  logic        vip_full;

  int checks = 0;
  int failures = 0;
  int e_cnt = 0;
  int beats = 0;
  int halt_cnt = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  ospfb_adc_subsys dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .m_axis_fir_tdata(fir_tdata), .m_axis_fir_tvalid(fir_tvalid), .m_axis_fir_tlast(fir_tlast),
    .m_axis_fft_status_tdata(st_tdata), .m_axis_fft_status_tvalid(st_tvalid),
    .event_frame_started(ev_fs), .event_tlast_unexpected(ev_tu), .event_tlast_missing(ev_tm),
    .event_fft_overflow(ev_ovf), .event_data_in_channel_halt(ev_halt),
    .almost_empty(a_empty), .almost_full(a_full), .prog_empty(p_empty), .prog_full(p_full),
    .rd_count(rd_count), .wr_count(wr_count), .vip_full(vip_full)
  );

  // Expected beat k: ramp value k mod 256 as a signed 8-bit number; im is its bitwise inverse
  function automatic logic [31:0] exp_beat(input int k);
    int v;
    v = k % 256;
    if (v >= 128) v = v - 256;
    return {16'(-1 - v), 16'(v)};
  endfunction

  // Enabled clock edges since reset
  always @(posedge clk) begin
    if (!rst_n) e_cnt = 0;
    else if (en) e_cnt = e_cnt + 1;
  end

  // Stream observer
  always @(negedge clk) begin : mon
    int prev;
    if (!rst_n) begin
      beats = 0;
      halt_cnt = 0;
    end else if (mon_en) begin
      prev = beats;
      if (fir_tvalid) begin
        checks++;
        if (fir_tdata !== exp_beat(beats)) begin
          failures++;
          $display("FAIL beat_data k=%0d got=%h exp=%h", beats, fir_tdata, exp_beat(beats));
        end
        checks++;
        if (fir_tlast !== (beats % FFT_LEN == FFT_LEN - 1) || ev_fs !== (beats % FFT_LEN == 0)) begin
          failures++;
          $display("FAIL framing k=%0d tlast=%b fs=%b", beats, fir_tlast, ev_fs);
        end
        checks++;
        if (beats % FFT_LEN == FFT_LEN - 1) begin
          if (st_tvalid !== 1'b1 || st_tdata !== 8'((beats / FFT_LEN + 1) % 256)) begin
            failures++;
            $display("FAIL status k=%0d got=%b/%0d exp=1/%0d", beats, st_tvalid, st_tdata,
                     (beats / FFT_LEN + 1) % 256);
          end
        end else if (st_tvalid !== 1'b0) begin
          failures++;
          $display("FAIL status_tvalid k=%0d got=1 exp=0", beats);
        end
        beats++;
      end else begin
        checks++;
        if (fir_tlast !== 1'b0 || ev_fs !== 1'b0 || st_tvalid !== 1'b0) begin
          failures++;
          $display("FAIL idle_pulses tlast=%b fs=%b st=%b exp=0", fir_tlast, ev_fs, st_tvalid);
        end
      end
      checks++;
      if (int'(wr_count) + beats != (e_cnt * DEC_FAC) / FFT_LEN) begin
        failures++;
        $display("FAIL conservation got=%0d exp=%0d", int'(wr_count) + beats, (e_cnt * DEC_FAC) / FFT_LEN);
      end
      checks++;
      if (vip_full !== (prev >= SAMP)) begin
        failures++;
        $display("FAIL vip_full beats=%0d got=%b exp=%b", prev, vip_full, prev >= SAMP);
      end
      checks++;
      if (rd_count !== wr_count || a_empty !== (wr_count <= 1) || a_full !== (wr_count >= DEPTH - 1) ||
          p_empty !== (wr_count <= THRESH) || p_full !== (wr_count >= THRESH)) begin
        failures++;
        $display("FAIL flags cnt=%0d rd=%0d ae=%b af=%b pe=%b pf=%b", wr_count, rd_count,
                 a_empty, a_full, p_empty, p_full);
      end
      checks++;
      if (ev_ovf !== 1'b0 || ev_tu !== 1'b0 || ev_tm !== 1'b0 || (ev_halt && fir_tvalid)) begin
        failures++;
        $display("FAIL events ovf=%b tu=%b tm=%b halt=%b valid=%b exp=0", ev_ovf, ev_tu, ev_tm,
                 ev_halt, fir_tvalid);
      end
      if (ev_halt) halt_cnt++;
    end
  end

  task automatic test_reset;
    mon_en = 1'b0;
    en = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fir_tdata, fir_tvalid, fir_tlast, st_tdata, st_tvalid, ev_fs, ev_ovf, ev_halt,
         a_full, p_full, rd_count, wr_count, vip_full} !== '0 || a_empty !== 1'b1 || p_empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_values tdata=%h v=%b cnt=%0d ae=%b pe=%b vf=%b", fir_tdata, fir_tvalid,
               wr_count, a_empty, p_empty, vip_full);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_init_rate;
    mon_en = 1'b1;
    en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (int'(wr_count) != (k * DEC_FAC) / FFT_LEN || fir_tvalid !== 1'b0) begin
        failures++;
        $display("FAIL init_fill k=%0d got=%0d exp=%0d valid=%b", k, wr_count, (k * DEC_FAC) / FFT_LEN, fir_tvalid);
      end
    end
  endtask

  task automatic test_stream(input int target, input int p_en);
    int cyc;
    cyc = 0;
    while (beats < target && cyc < 20000) begin
      @(negedge clk);
      en = ($urandom_range(0, 99) < p_en);
      cyc++;
    end
    checks++;
    if (beats < target) begin
      failures++;
      $display("FAIL stream_timeout beats=%0d exp>=%0d", beats, target);
    end
  endtask

  task automatic test_en_pause;
    int h0;
    @(negedge clk);
    en = 1'b0;
    h0 = halt_cnt;
    repeat (100) @(negedge clk);
    checks++;
    if (wr_count !== 6'd0) begin
      failures++;
      $display("FAIL pause_drain got=%0d exp=0", wr_count);
    end
    checks++;
    if (halt_cnt <= h0) begin
      failures++;
      $display("FAIL pause_halt got=%0d exp>0", halt_cnt - h0);
    end
    en = 1'b1;
  endtask

  task automatic test_capture;
    int bad;
    bad = 0;
    checks++;
    if (vip_full !== 1'b1 || st_tdata !== 8'd32) begin
      failures++;
      $display("FAIL capture_done vip_full=%b status=%0d exp=1/32", vip_full, st_tdata);
    end
    for (int i = 0; i < SAMP; i++) begin
      checks++;
      if (dut.ram[i] !== exp_beat(i)) begin
        failures++;
        if (bad < 5) $display("FAIL ram i=%0d got=%h exp=%h", i, dut.ram[i], exp_beat(i));
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid;
    test_stream(beats + 20, 100);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({fir_tdata, fir_tvalid, fir_tlast, st_tdata, st_tvalid, ev_fs, ev_halt, wr_count, vip_full} !== '0 ||
        a_empty !== 1'b1 || p_empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid tdata=%h v=%b st=%0d cnt=%0d vf=%b ae=%b pe=%b", fir_tdata, fir_tvalid,
               st_tdata, wr_count, vip_full, a_empty, p_empty);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    test_stream(80, 100);
    checks++;
    if (dut.ram[0] !== exp_beat(0) || dut.ram[70] !== exp_beat(70) || vip_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_restart ram0=%h ram70=%h vf=%b exp=%h/%h/0", dut.ram[0], dut.ram[70],
               vip_full, exp_beat(0), exp_beat(70));
    end
  endtask

  initial begin
    test_reset();
    test_init_rate();
    test_stream(300, 90);
    test_en_pause();
    test_stream(SAMP + 10, 85);
    test_capture();
    test_reset_mid();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
